demux_1_n_buf: RTL and testbench

//  Buffered 1-to-N stream demultiplexer; the inverse of the team's 2:1/N:1 select muxes.

---
 rtl/demux_1_n_buf.sv | 78 +++++++
 tb/tb_demux_1_n_buf.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1_n_buf.sv
// Buffered 1-to-N valid/ready demultiplexer: each word goes to the lane named by in_sel,
// and each lane has one holding register. Out-of-range selects are accepted, dropped and counted.
module demux_1_n_buf #(
  parameter int unsigned N_OUT     = 4,
  parameter int unsigned SEL_W     = 2,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic                    err_pulse,
  output logic [ERR_CNT_W-1:0]    err_count
);

  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic [DATA_W-1:0] data_q [N_OUT];
  logic [N_OUT-1:0]  valid_q;
  logic [N_OUT-1:0]  sel_hot;
  logic [N_OUT-1:0]  load;
  logic              sel_ok;
  logic              drop;

  // Decode the select one-hot so no lane index can run past N_OUT-1.
  // A lane that is FULL can still take a new word when its consumer drains it on the same edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    sel_ok   = 1'b0;
    sel_hot  = '0;
    in_ready = 1'b1;
    for (int k = 0; k < N_OUT; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_ok     = 1'b1;
        sel_hot[k] = 1'b1;
        in_ready   = ~valid_q[k] | out_ready[k];
      end
    end
    load = sel_hot & {N_OUT{in_valid & in_ready}};
    drop = in_valid & ~sel_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      // NOTE: the lane data registers are reset too, because out_data must read zero during and after reset.
      for (int k = 0; k < N_OUT; k++) data_q[k] <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every lane sees pre-edge values.
      for (int k = 0; k < N_OUT; k++) begin
        if (load[k]) begin
          valid_q[k] <= 1'b1;
          data_q[k]  <= in_data;
        end else if (valid_q[k] && out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
      err_pulse <= drop;
      if (drop && err_count != ERR_MAX) err_count <= err_count + 1'b1;
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < N_OUT; k++) out_data[k*DATA_W +: DATA_W] = data_q[k];
  end

  assign out_valid = valid_q;

endmodule

// File: tb/tb_demux_1_n_buf.sv
// Self-checking bench for demux_1_n_buf: a 4-lane instance for routing, stalls and a random soak,
// and a 3-lane instance with a 2-bit counter for out-of-range drops and counter saturation.
module tb_demux_1_n_buf;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        err_pulse;
  logic [7:0]  err_count;

  logic [7:0]  b_in_data;
  logic [1:0]  b_in_sel;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [23:0] b_out_data;
  logic [2:0]  b_out_valid;
  logic [2:0]  b_out_ready;
  logic        b_err_pulse;
  logic [1:0]  b_err_count;

  demux_1_n_buf #(.N_OUT(4), .SEL_W(2), .DATA_W(8), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  demux_1_n_buf #(.N_OUT(3), .SEL_W(2), .DATA_W(8), .ERR_CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_sel(b_in_sel), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .err_pulse(b_err_pulse), .err_count(b_err_count)
  );

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    logic [3:0] exp_valid;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] sb [4][$];
  int         n_checks;
  int         n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lane(input int k);
    return out_data[k*8 +: 8];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) sb[k].delete();
    step();
  endtask

  initial begin
    logic [3:0] mask;
    logic       exp_ready;
    logic [7:0] exp_d;

    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = '0;
    b_in_data = '0; b_in_sel = '0; b_in_valid = 1'b0; b_out_ready = '0;

    vecs[0] = '{sel: 2'd0, data: 8'h5A, exp_valid: 4'b0001};
    vecs[1] = '{sel: 2'd1, data: 8'hC3, exp_valid: 4'b0010};
    vecs[2] = '{sel: 2'd2, data: 8'h0F, exp_valid: 4'b0100};
    vecs[3] = '{sel: 2'd3, data: 8'hF0, exp_valid: 4'b1000};

    #12;
    rst_n = 1'b1;
    step();
    check("reset_valid", 32'(out_valid), 32'h0);
    check("reset_data", out_data, 32'h0);
    check("reset_err_pulse", 32'(err_pulse), 32'h0);
    check("reset_err_count", 32'(err_count), 32'h0);

    // Table: a single word into each lane from empty, one lane at a time.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sel = vecs[i].sel; in_data = vecs[i].data;
      #1;
      check("tbl_in_ready", 32'(in_ready), 32'h1);
      step();
      in_valid = 1'b0;
      #1;
      check("tbl_valid", 32'(out_valid), 32'(vecs[i].exp_valid));
      check("tbl_data", 32'(lane(vecs[i].sel)), 32'(vecs[i].data));
      check("tbl_err_pulse", 32'(err_pulse), 32'h0);
      out_ready = 4'hF;
      step();
      out_ready = '0;
      check("tbl_drained", 32'(out_valid), 32'h0);
    end

    // Asynchronous reset while ch2 is FULL and another word is pending.
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h77;
    step();
    check("rst_pre_valid", 32'(out_valid), 32'h4);
    in_data = 8'h78;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(out_valid), 32'h0);
    check("rst_async_count", 32'(err_count), 32'h0);
    check("rst_async_data", out_data, 32'h0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    check("rst_release_valid", 32'(out_valid), 32'h0);

    // Routing to lane 1, then a stalled second word.
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hA5; out_ready = '0;
    step();
    check("route_valid", 32'(out_valid), 32'h2);
    check("route_data", 32'(lane(1)), 32'hA5);
    in_data = 8'h99;
    #1;
    check("route_blocked", 32'(in_ready), 32'h0);
    for (int c = 0; c < 5; c++) begin
      step();
      check("stall_ready", 32'(in_ready), 32'h0);
      check("stall_valid", 32'(out_valid), 32'h2);
      check("stall_data", 32'(lane(1)), 32'hA5);
    end
    out_ready = 4'b0010; in_data = 8'h3C;
    #1;
    check("pass_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0; out_ready = '0;
    check("nobubble_valid", 32'(out_valid), 32'h2);
    check("nobubble_data", 32'(lane(1)), 32'h3C);
    out_ready = 4'b0010;
    step();
    out_ready = '0;
    check("drain_valid", 32'(out_valid), 32'h0);
    check("drain_hold_data", 32'(lane(1)), 32'h3C);

    // Fill all four lanes, then drain in order 3,0,2,1 through the scoreboard.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sel = 2'(k); in_data = 8'h10 + 8'(k);
      #1;
      if (in_ready) sb[k].push_back(in_data);
      step();
    end
    in_valid = 1'b0;
    mask = 4'hF;
    check("par_full", 32'(out_valid), 32'(mask));
    for (int j = 0; j < 4; j++) begin
      int k;
      k = (j == 0) ? 3 : (j == 1) ? 0 : (j == 2) ? 2 : 1;
      out_ready = 4'(1 << k);
      #1;
      if (sb[k].size() != 0) begin
        exp_d = sb[k].pop_front();
        check("par_data", 32'(lane(k)), 32'(exp_d));
      end else begin
        n_checks++;
        $display("FAIL par_sb lane %0d: got no queued word, required one", k);
      end
      step();
      out_ready = '0;
      mask[k] = 1'b0;
      check("par_mask", 32'(out_valid), 32'(mask));
    end

    // Out-of-range drops on the 3-lane instance, then counter saturation.
    b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 8'hEE;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("oor_ready", 32'(b_in_ready), 32'h1);
      step();
      check("oor_pulse", 32'(b_err_pulse), 32'h1);
      check("oor_valid", 32'(b_out_valid), 32'h0);
    end
    b_in_valid = 1'b0;
    check("oor_count3", 32'(b_err_count), 32'h3);
    step();
    check("oor_pulse_off", 32'(b_err_pulse), 32'h0);
    b_in_valid = 1'b1;
    step();
    step();
    b_in_valid = 1'b0;
    check("oor_saturated", 32'(b_err_count), 32'h3);
    check("oor_inrange_pulse", 32'(err_pulse), 32'h0);

    // Random soak against a per-lane scoreboard.
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
      #1;
      for (int k = 0; k < 4; k++) mask[k] = (sb[k].size() != 0);
      check("soak_valid", 32'(out_valid), 32'(mask));
      exp_ready = ~mask[in_sel] | out_ready[in_sel];
      check("soak_ready", 32'(in_ready), 32'(exp_ready));
      for (int k = 0; k < 4; k++) begin
        if (mask[k]) begin
          check("soak_data", 32'(lane(k)), 32'(sb[k][0]));
          if (out_ready[k]) void'(sb[k].pop_front());
        end
      end
      if (in_valid && exp_ready) sb[in_sel].push_back(in_data);
      step();
    end
    in_valid = 1'b0; out_ready = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
